// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter that shares one UART transmitter among
// several byte-stream requesters, sequencing the start/busy handshake with timeouts.
module uart_tx_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int TIMEOUT    = 100_000,
    localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          tx_start_o,
    output logic [DATA_WIDTH-1:0]         tx_data_o,
    input  logic                          tx_busy_i,
    output logic                          grant_valid_o,
    output logic [ID_W-1:0]               grant_id_o,
    output logic                          err_timeout_o
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int SW = ID_W + 1;

    typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, HOLD} state_e;

    state_e                 state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [ID_W-1:0]        rrPtr_q, rrPtr_d;
    logic [ID_W-1:0]        grantId_q, grantId_d;
    logic [DATA_WIDTH-1:0]  txData_q, txData_d;
    logic                   last_q, last_d;
    logic                   grantValid_q, grantValid_d;
    logic                   txStart_q, txStart_d;
    logic                   err_q, err_d;

    logic                   winFound;
    logic [ID_W-1:0]        winId, cand, selId, nextPtr;
    logic [SW-1:0]          sum;
    logic [DATA_WIDTH-1:0]  selData;
    logic                   selLast, selValid, timerExpired;
    logic [NUM_REQ-1:0]     selOneHot, readyVec;

    // Lowest offset from the pointer wins, so iterate from the far end down.
    always_comb begin
        winFound = 1'b0;
        winId    = '0;
        sum      = '0;
        cand     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum  = {1'b0, rrPtr_q} + SW'(k);
            cand = (sum >= SW'(NUM_REQ)) ? ID_W'(sum - SW'(NUM_REQ)) : ID_W'(sum);
            if (req_valid_i[cand]) begin
                winFound = 1'b1;
                winId    = cand;
            end
        end
    end

    assign selId = (state_q == HOLD) ? grantId_q : winId;

    always_comb begin
        selData   = '0;
        selLast   = 1'b0;
        selValid  = 1'b0;
        selOneHot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == selId) begin
                selData      = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                selLast      = req_last_i[i];
                selValid     = req_valid_i[i];
                selOneHot[i] = 1'b1;
            end
        end
    end

    assign nextPtr      = (grantId_q == ID_W'(NUM_REQ - 1)) ? '0 : grantId_q + ID_W'(1);
    assign timerExpired = (timer_q == TW'(TIMEOUT - 2));

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        rrPtr_d      = rrPtr_q;
        grantId_d    = grantId_q;
        txData_d     = txData_q;
        last_d       = last_q;
        grantValid_d = grantValid_q;
        txStart_d    = 1'b0;
        err_d        = 1'b0;
        readyVec     = '0;
        case (state_q)
            IDLE: begin
                if (winFound) begin
                    readyVec     = selOneHot;
                    txData_d     = selData;
                    last_d       = selLast;
                    grantId_d    = winId;
                    grantValid_d = 1'b1;
                    txStart_d    = 1'b1;
                    state_d      = START;
                end
            end
            START: begin
                timer_d = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy_i) begin
                    state_d = WAIT_DONE;
                end else if (timerExpired) begin
                    err_d        = 1'b1;
                    grantValid_d = 1'b0;
                    rrPtr_d      = nextPtr;
                    state_d      = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy_i) begin
                    if (last_q) begin
                        grantValid_d = 1'b0;
                        rrPtr_d      = nextPtr;
                        state_d      = IDLE;
                    end else begin
                        timer_d = '0;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                readyVec = selOneHot;
                if (selValid) begin
                    txData_d  = selData;
                    last_d    = selLast;
                    txStart_d = 1'b1;
                    state_d   = START;
                end else if (timerExpired) begin
                    err_d        = 1'b1;
                    grantValid_d = 1'b0;
                    rrPtr_d      = nextPtr;
                    state_d      = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            rrPtr_q      <= '0;
            grantId_q    <= '0;
            txData_q     <= '0;
            last_q       <= 1'b0;
            grantValid_q <= 1'b0;
            txStart_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            rrPtr_q      <= rrPtr_d;
            grantId_q    <= grantId_d;
            txData_q     <= txData_d;
            last_q       <= last_d;
            grantValid_q <= grantValid_d;
            txStart_q    <= txStart_d;
            err_q        <= err_d;
        end
    end

    // Ready is combinational, so hold it low while reset is asserted.
    assign req_ready_o   = rst_n ? readyVec : '0;
    assign tx_start_o    = txStart_q;
    assign tx_data_o     = txData_q;
    assign grant_valid_o = grantValid_q;
    assign grant_id_o    = grantId_q;
    assign err_timeout_o = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queued requesters, a simple transmitter model
// and a frame-level scoreboard with round-robin reference.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int TO   = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  reqValid, reqLast, reqReady;
    logic [31:0] reqData;
    logic        txStart, txBusy, grantValid, errTimeout;
    logic [7:0]  txData;
    logic [1:0]  grantId;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(NREQ), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (reqValid),
        .req_data_i   (reqData),
        .req_last_i   (reqLast),
        .req_ready_o  (reqReady),
        .tx_start_o   (txStart),
        .tx_data_o    (txData),
        .tx_busy_i    (txBusy),
        .grant_valid_o(grantValid),
        .grant_id_o   (grantId),
        .err_timeout_o(errTimeout)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int t0;

    logic [8:0]  reqBuf [4][16];
    int          reqHead [4] = '{default: 0};
    int          reqTail [4] = '{default: 0};
    logic [10:0] expQ [$];

    int          modelPtr;
    logic [1:0]  curId;
    logic [7:0]  curData;
    logic        curLast, prevGv;
    bit          busyNever = 1'b0;
    bit          errAllowed = 1'b0;
    int          riseDelay = 2;
    int          busyLen = 10;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int id, input logic [7:0] data, input logic last);
        reqBuf[id][reqTail[id]] = {last, data};
        reqTail[id]++;
    endtask

    task automatic expectFrame(input int id, input logic [7:0] data, input logic last);
        expQ.push_back({last, 2'(id), data});
    endtask

    function automatic logic [3:0] pickMask(input int ptr, input logic [3:0] v);
        for (int k = 0; k < 4; k++) begin
            int idx = (ptr + k) % 4;
            if (v[idx]) return 4'b0001 << idx;
        end
        return 4'b0000;
    endfunction

    // which: 0 tx_start, 1 err_timeout, 2 tx_busy, 3 grant_valid
    task automatic waitSignal(input string name, input int which, input logic val);
        logic s;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            case (which)
                0: s = txStart;
                1: s = errTimeout;
                2: s = txBusy;
                default: s = grantValid;
            endcase
            if (s === val) return;
        end
        vectors++;
        miscompares++;
        $display("[TB] FAIL wait_%s: signal never reached %0d within 500 cycles", name, val);
    endtask

    task automatic waitIdle(input string name);
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (expQ.size() == 0 && !grantValid && !txBusy &&
                reqHead[0] == reqTail[0] && reqHead[1] == reqTail[1] &&
                reqHead[2] == reqTail[2] && reqHead[3] == reqTail[3]) return;
        end
        vectors++;
        miscompares++;
        $display("[TB] FAIL idle_%s: arbiter did not drain within 2000 cycles, %0d frames pending", name, expQ.size());
    endtask

    // Requester drivers: present queue heads, pop on an accepted handshake.
    initial begin
        logic [3:0] fire;
        reqValid = '0;
        reqData  = '0;
        reqLast  = '0;
        forever begin
            @(negedge clk);
            fire = reqValid & reqReady;
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (fire[i]) reqHead[i]++;
                if (reqHead[i] < reqTail[i]) begin
                    reqValid[i]       = 1'b1;
                    reqData[i*8 +: 8] = reqBuf[i][reqHead[i]][7:0];
                    reqLast[i]        = reqBuf[i][reqHead[i]][8];
                end else begin
                    reqValid[i]       = 1'b0;
                    reqData[i*8 +: 8] = 8'h00;
                    reqLast[i]        = 1'b0;
                end
            end
        end
    end

    // Transmitter model: busy rises riseDelay cycles after start, lasts busyLen cycles.
    initial begin
        txBusy = 1'b0;
        forever begin
            @(negedge clk);
            if (txStart && !busyNever) begin
                repeat (riseDelay) @(posedge clk);
                #1 txBusy = 1'b1;
                repeat (busyLen) @(posedge clk);
                #1 txBusy = 1'b0;
            end
        end
    end

    // Scoreboard: frame order, grant ownership, ready legality, release causes.
    initial begin
        logic [10:0] e;
        modelPtr = 0;
        prevGv   = 1'b0;
        curId    = '0;
        curData  = '0;
        curLast  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                expQ.delete();
                modelPtr = 0;
                prevGv   = 1'b0;
            end else begin
                if (prevGv && !grantValid) begin
                    checkOutput("release_cause", 32'(curLast | errTimeout), 32'd1);
                    modelPtr = (int'(curId) + 1) % 4;
                end
                if (txStart) begin
                    if (expQ.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("[TB] FAIL unexpected_start: got start for id %0d data 0x%0h, expected none", grantId, txData);
                    end else begin
                        e       = expQ.pop_front();
                        curLast = e[10];
                        curId   = e[9:8];
                        curData = e[7:0];
                        checkOutput("start_grant_id", 32'(grantId), 32'(curId));
                        checkOutput("start_tx_data", 32'(txData), 32'(curData));
                        checkOutput("start_grant_valid", 32'(grantValid), 32'd1);
                    end
                end
                if (grantValid) begin
                    checkOutput("grant_id_held", 32'(grantId), 32'(curId));
                    checkOutput("ready_locked", 32'(reqReady & ~(4'b0001 << curId)), 32'd0);
                    if (txBusy) begin
                        checkOutput("tx_data_stable", 32'(txData), 32'(curData));
                        checkOutput("ready_busy", 32'(reqReady), 32'd0);
                    end
                end else begin
                    checkOutput("ready_arbiter", 32'(reqReady), 32'(pickMask(modelPtr, reqValid)));
                    checkOutput("tx_start_idle", 32'(txStart), 32'd0);
                end
                if (!errAllowed) checkOutput("err_spurious", 32'(errTimeout), 32'd0);
                prevGv = grantValid;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_tx_start", 32'(txStart), 32'd0);
        checkOutput("reset_tx_data", 32'(txData), 32'd0);
        checkOutput("reset_grant_valid", 32'(grantValid), 32'd0);
        checkOutput("reset_grant_id", 32'(grantId), 32'd0);
        checkOutput("reset_err", 32'(errTimeout), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        $display("[TB] single byte from requester 1");
        expectFrame(1, 8'hA5, 1'b1);
        applyStimulus(1, 8'hA5, 1'b1);
        waitSignal("start_single", 0, 1'b1);
        checkOutput("single_grant_id", 32'(grantId), 32'd1);
        waitSignal("busy_rise_single", 2, 1'b1);
        waitSignal("busy_fall_single", 2, 1'b0);
        checkOutput("gv_at_busy_fall", 32'(grantValid), 32'd1);
        @(negedge clk);
        checkOutput("gv_after_busy_fall", 32'(grantValid), 32'd0);
        waitIdle("single");

        $display("[TB] pointer after single byte, then wrap");
        expectFrame(3, 8'h3C, 1'b1);
        expectFrame(0, 8'h0C, 1'b1);
        applyStimulus(0, 8'h0C, 1'b1);
        applyStimulus(3, 8'h3C, 1'b1);
        waitSignal("start_ptr", 0, 1'b1);
        checkOutput("rr_ptr_is_2", 32'(grantId), 32'd3);
        waitIdle("ptr");
        expectFrame(3, 8'h3D, 1'b1);
        applyStimulus(3, 8'h3D, 1'b1);
        waitIdle("wrap");

        $display("[TB] round robin, all requesters valid");
        expectFrame(0, 8'h50, 1'b1);
        expectFrame(1, 8'h51, 1'b1);
        expectFrame(2, 8'h52, 1'b1);
        expectFrame(3, 8'h53, 1'b1);
        expectFrame(0, 8'h54, 1'b1);
        applyStimulus(0, 8'h50, 1'b1);
        applyStimulus(0, 8'h54, 1'b1);
        applyStimulus(1, 8'h51, 1'b1);
        applyStimulus(2, 8'h52, 1'b1);
        applyStimulus(3, 8'h53, 1'b1);
        waitIdle("round_robin");

        $display("[TB] packet lock");
        expectFrame(0, 8'h11, 1'b0);
        expectFrame(0, 8'h22, 1'b0);
        expectFrame(0, 8'h33, 1'b1);
        expectFrame(2, 8'h44, 1'b1);
        applyStimulus(0, 8'h11, 1'b0);
        applyStimulus(0, 8'h22, 1'b0);
        applyStimulus(0, 8'h33, 1'b1);
        waitSignal("start_lock", 0, 1'b1);
        applyStimulus(2, 8'h44, 1'b1);
        waitSignal("busy_rise_lock", 2, 1'b1);
        waitSignal("busy_fall_lock", 2, 1'b0);
        @(negedge clk);
        checkOutput("hold_ready_owner_only", 32'(reqReady), 32'h1);
        waitIdle("lock");

        $display("[TB] busy timeout");
        busyNever  = 1'b1;
        errAllowed = 1'b1;
        expectFrame(3, 8'h77, 1'b1);
        expectFrame(0, 8'h88, 1'b1);
        applyStimulus(3, 8'h77, 1'b1);
        applyStimulus(0, 8'h88, 1'b1);
        waitSignal("start_busy_to", 0, 1'b1);
        t0 = cyc;
        waitSignal("err_busy_to", 1, 1'b1);
        checkOutput("busy_timeout_cycles", 32'(cyc - t0), 32'd16);
        checkOutput("busy_timeout_gv", 32'(grantValid), 32'd0);
        busyNever = 1'b0;
        @(negedge clk);
        checkOutput("err_one_cycle", 32'(errTimeout), 32'd0);
        waitIdle("busy_to");
        errAllowed = 1'b0;

        $display("[TB] hold timeout");
        errAllowed = 1'b1;
        expectFrame(3, 8'h99, 1'b0);
        applyStimulus(3, 8'h99, 1'b0);
        waitSignal("start_hold_to", 0, 1'b1);
        waitSignal("busy_rise_hold", 2, 1'b1);
        waitSignal("busy_fall_hold", 2, 1'b0);
        t0 = cyc;
        waitSignal("err_hold_to", 1, 1'b1);
        checkOutput("hold_timeout_cycles", 32'(cyc - t0), 32'd16);
        checkOutput("hold_timeout_gv", 32'(grantValid), 32'd0);
        waitIdle("hold_to");
        errAllowed = 1'b0;

        expectFrame(1, 8'hB1, 1'b1);
        applyStimulus(1, 8'hB1, 1'b1);
        waitIdle("pre_reset");

        $display("[TB] reset mid-packet");
        expectFrame(2, 8'hC3, 1'b1);
        applyStimulus(2, 8'hC3, 1'b1);
        waitSignal("start_reset", 0, 1'b1);
        waitSignal("busy_rise_reset", 2, 1'b1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_tx_start", 32'(txStart), 32'd0);
        checkOutput("rst_tx_data", 32'(txData), 32'd0);
        checkOutput("rst_grant_valid", 32'(grantValid), 32'd0);
        checkOutput("rst_grant_id", 32'(grantId), 32'd0);
        checkOutput("rst_err", 32'(errTimeout), 32'd0);
        checkOutput("rst_ready", 32'(reqReady), 32'd0);
        waitSignal("busy_fall_reset", 2, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        expectFrame(0, 8'hD4, 1'b1);
        expectFrame(2, 8'hE5, 1'b1);
        applyStimulus(0, 8'hD4, 1'b1);
        applyStimulus(2, 8'hE5, 1'b1);
        waitSignal("start_after_reset", 0, 1'b1);
        checkOutput("post_reset_grant", 32'(grantId), 32'd0);
        waitIdle("after_reset");

        checkOutput("frames_outstanding", 32'(expQ.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
